// File: rtl/alu_mc_if.sv
// ---------------------------------------------------------------------------
// alu_mc_if -- request/response bus of the multi-cycle ALU.
//   Request  (master -> slave): in_valid, A, B, Cin, Op, invA, invB, sign
//   Request  (slave -> master): in_ready
//   Response (slave -> master): out_valid, Out, Ofl, Z, resultSign, busy
//   Response (master -> slave): out_ready
// ---------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [3:0]       Op;
  logic             invA;
  logic             invB;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Ofl;
  logic             Z;
  logic             resultSign;
  logic             busy;

  modport master (
    output in_valid, A, B, Cin, Op, invA, invB, sign, out_ready,
    input  in_ready, out_valid, Out, Ofl, Z, resultSign, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, Op, invA, invB, sign, out_ready,
    output in_ready, out_valid, Out, Ofl, Z, resultSign, busy
  );
endinterface

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- ALU with single-cycle shift/add/logic ops and an iterative
// shift-add multiplier (one multiplier bit per cycle).
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_mc_if.slave -- valid/ready request carrying A, B, Cin, Op,
//            invA, invB, sign; valid/ready response carrying the registered
//            Out, Ofl, Z, resultSign; busy while a multiply is running.
// Single-cycle results are loaded on the transfer edge. MUL/MULH enter the
// MUL state for WIDTH+1 cycles and load the result on leaving it.
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus
);
  localparam int                CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               neg_q, msign_q, hi_q;
  logic [WIDTH-1:0]   out_q;
  logic               ofl_q, out_valid_q;

  logic [WIDTH-1:0]   a_new, b_new, mag_a, mag_b;
  logic [SHW-1:0]     sh, sh_neg;
  logic               xfer, mul_req, mul_done;

  assign a_new   = bus.invA ? ~bus.A : bus.A;
  assign b_new   = bus.invB ? ~bus.B : bus.B;
  assign sh      = b_new[SHW-1:0];
  // Complementary rotate amount; for sh==0 both halves equal a_new, so the
  // OR still returns a_new unchanged.
  assign sh_neg  = -sh;
  assign mul_req = (bus.Op == 4'b1001) || (bus.Op == 4'b1010);

  assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign mul_done     = (state_q == MUL) && (cnt_q == CNT_LAST);

  // Unsigned magnitudes for signed multiply; the most-negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  assign mag_a = (bus.sign && a_new[WIDTH-1]) ? (~a_new + ONE_W) : a_new;
  assign mag_b = (bus.sign && b_new[WIDTH-1]) ? (~b_new + ONE_W) : b_new;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_w;
  logic             add_cmsb;
  logic [WIDTH-1:0] rev_w, slbi_w, res;
  logic             res_ofl;

  always_comb begin
    // NOTE: every output of an always_comb gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    res     = '0;
    res_ofl = 1'b0;
    add_w    = {1'b0, a_new} + {1'b0, b_new} + {{WIDTH{1'b0}}, bus.Cin};
    add_cmsb = add_w[WIDTH-1] ^ a_new[WIDTH-1] ^ b_new[WIDTH-1];
    for (int i = 0; i < WIDTH; i++) rev_w[i] = a_new[WIDTH-1-i];
    slbi_w = (bus.A << (WIDTH/2)) | {{(WIDTH/2){1'b0}}, bus.B[WIDTH/2-1:0]};
    case (bus.Op)
      4'b0000: res = (a_new << sh) | (a_new >> sh_neg);
      4'b0001: res = a_new << sh;
      4'b0010: res = (a_new >> sh) | (a_new << sh_neg);
      4'b0011: res = a_new >> sh;
      4'b0100: begin
        res     = add_w[WIDTH-1:0];
        res_ofl = bus.sign ? (add_w[WIDTH] ^ add_cmsb) : add_w[WIDTH];
      end
      4'b0101: res = b_new - a_new;
      4'b0110: res = bus.A ^ bus.B;
      4'b0111: res = bus.A & ~bus.B;
      4'b1000: res = rev_w;
      4'b1100, 4'b1101: res = b_new;
      4'b1110, 4'b1111: res = slbi_w;
      default: res = '0;  // 1001/1010 go to the multiplier, 1011 reserved
    endcase
  end

  // ---------------- multiplier datapath ----------------
  // prod_q = {partial high half, remaining multiplier bits}; each step adds
  // mcand when the current multiplier LSB is set and shifts right by one.
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   mul_hi, mul_lo, mul_out;
  logic               mul_ofl;

  assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_fin = neg_q ? (~prod_q + ONE_2W) : prod_q;
  assign mul_hi   = prod_fin[2*WIDTH-1:WIDTH];
  assign mul_lo   = prod_fin[WIDTH-1:0];
  assign mul_out  = hi_q ? mul_hi : mul_lo;
  assign mul_ofl  = hi_q    ? 1'b0 :
                    msign_q ? (mul_hi != {WIDTH{mul_lo[WIDTH-1]}}) : (|mul_hi);

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && mul_req) state_d = MUL;
      MUL:     if (cnt_q == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the multiplier registers are reset too, so an operation abandoned
  // by reset leaves no stale partial product behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      msign_q <= 1'b0;
      hi_q    <= 1'b0;
    end else if (xfer && mul_req) begin
      cnt_q   <= '0;
      mcand_q <= mag_a;
      prod_q  <= {{WIDTH{1'b0}}, mag_b};
      neg_q   <= bus.sign & (a_new[WIDTH-1] ^ b_new[WIDTH-1]);
      msign_q <= bus.sign;
      hi_q    <= bus.Op[1];
    end else if (state_q == MUL) begin
      if (mul_done) begin
        cnt_q <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        prod_q <= {step_sum, prod_q[WIDTH-1:1]};
      end
    end
  end

  // Result registers: multiply completion, single-cycle transfer, or plain
  // consumption (Out keeps its last value, only out_valid drops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      ofl_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (mul_done) begin
      out_q       <= mul_out;
      ofl_q       <= mul_ofl;
      out_valid_q <= 1'b1;
    end else if (xfer && !mul_req) begin
      out_q       <= res;
      ofl_q       <= res_ofl;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.Out        = out_q;
  assign bus.Ofl        = ofl_q;
  assign bus.Z          = (out_q == '0);
  assign bus.resultSign = out_q[WIDTH-1];
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q == MUL);
endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc at WIDTH 16, 32, 8.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(16)) b16 ();
  alu_mc_if #(.WIDTH(32)) b32 ();
  alu_mc_if #(.WIDTH(8))  b8  ();

  alu_mc #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  alu_mc #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  alu_mc #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic ia, input logic ib, input logic sgn);
    b16.Op = op; b16.A = a; b16.B = b; b16.Cin = cin;
    b16.invA = ia; b16.invB = ib; b16.sign = sgn;
  endtask

  task automatic op16(input string tag, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic cin, input logic ia, input logic ib,
                      input logic sgn, input logic [15:0] exp_out, input logic exp_ofl);
    set16(op, a, b, cin, ia, ib, sgn);
    b16.in_valid  = 1'b1;
    b16.out_ready = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    chk({tag, " valid"}, b16.out_valid, 1'b1);
    chk({tag, " out"}, b16.Out, exp_out);
    chk({tag, " ofl"}, b16.Ofl, exp_ofl);
    chk({tag, " z"}, b16.Z, exp_out == 16'h0000);
    chk({tag, " rsign"}, b16.resultSign, exp_out[15]);
  endtask

  task automatic mul16(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic sgn,
                       input logic [15:0] exp_out, input logic exp_ofl);
    int k;
    set16(op, a, b, 1'b0, 1'b0, 1'b0, sgn);
    b16.in_valid  = 1'b1;
    b16.out_ready = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    chk({tag, " busy"}, b16.busy, 1'b1);
    chk({tag, " in_ready"}, b16.in_ready, 1'b0);
    k = 0;
    while (b16.out_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, k, 17);
    chk({tag, " out"}, b16.Out, exp_out);
    chk({tag, " ofl"}, b16.Ofl, exp_ofl);
    chk({tag, " busy done"}, b16.busy, 1'b0);
  endtask

  task automatic op8(input string tag, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] exp_out);
    b8.Op = op; b8.A = a; b8.B = b; b8.Cin = 1'b0;
    b8.invA = 1'b0; b8.invB = 1'b0; b8.sign = 1'b0;
    b8.in_valid  = 1'b1;
    b8.out_ready = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    chk({tag, " valid"}, b8.out_valid, 1'b1);
    chk({tag, " out"}, b8.Out, exp_out);
  endtask

  // Stream vectors: add, xor, pass B, sub.
  logic [3:0]  s_op  [4] = '{4'b0100, 4'b0110, 4'b1100, 4'b0101};
  logic [15:0] s_a   [4] = '{16'h0001, 16'h00FF, 16'h1111, 16'h0005};
  logic [15:0] s_b   [4] = '{16'h0002, 16'h0F0F, 16'hABCD, 16'h0003};
  logic [15:0] s_exp [4] = '{16'h0003, 16'h0FF0, 16'hABCD, 16'hFFFE};

  initial begin
    int k;
    int seen;
    rst_n = 1'b0;
    set16(4'b0000, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    b16.in_valid = 1'b0; b16.out_ready = 1'b0;
    b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.A = '0; b32.B = '0; b32.Cin = 1'b0;
    b32.Op = 4'b0000; b32.invA = 1'b0; b32.invB = 1'b0; b32.sign = 1'b0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.A = '0; b8.B = '0; b8.Cin = 1'b0;
    b8.Op = 4'b0000; b8.invA = 1'b0; b8.invB = 1'b0; b8.sign = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst out_valid", b16.out_valid, 1'b0);
    chk("rst busy", b16.busy, 1'b0);
    chk("rst out", b16.Out, 16'h0000);
    chk("rst ofl", b16.Ofl, 1'b0);
    chk("rst z", b16.Z, 1'b1);
    chk("rst rsign", b16.resultSign, 1'b0);
    chk("rst32 z", b32.Z, 1'b1);

    // Release and transfer on the very first edge: signed 7FFF+1 overflows
    rst_n = 1'b1;
    set16(4'b0100, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    b16.in_valid  = 1'b1;
    b16.out_ready = 1'b1;
    #1;
    chk("first in_ready", b16.in_ready, 1'b1);
    tick();
    b16.in_valid = 1'b0;
    chk("add ovf valid", b16.out_valid, 1'b1);
    chk("add ovf out", b16.Out, 16'h8000);
    chk("add ovf ofl", b16.Ofl, 1'b1);
    chk("add ovf rsign", b16.resultSign, 1'b1);
    chk("add ovf z", b16.Z, 1'b0);
    tick();
    chk("drain valid", b16.out_valid, 1'b0);
    chk("drain out kept", b16.Out, 16'h8000);

    // Single-cycle ops (tag, op, A, B, Cin, invA, invB, sign, Out, Ofl)
    op16("rotl4",     4'b0000, 16'h8001, 16'h0004, 0, 0, 0, 0, 16'h0018, 0);
    op16("shl15",     4'b0001, 16'h00FF, 16'h000F, 0, 0, 0, 0, 16'h8000, 0);
    op16("shl0",      4'b0001, 16'h1234, 16'h0010, 0, 0, 0, 0, 16'h1234, 0);
    op16("rotr15",    4'b0010, 16'h0001, 16'h000F, 0, 0, 0, 0, 16'h0002, 0);
    op16("shr15",     4'b0011, 16'h8000, 16'h000F, 0, 0, 0, 0, 16'h0001, 0);
    op16("add u cy",  4'b0100, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1);
    op16("add s -1+1",4'b0100, 16'hFFFF, 16'h0001, 0, 0, 0, 1, 16'h0000, 0);
    op16("add invA",  4'b0100, 16'h0000, 16'h0005, 1, 1, 0, 0, 16'h0005, 1);
    op16("sub",       4'b0101, 16'h0003, 16'h0001, 0, 0, 0, 1, 16'hFFFE, 0);
    op16("xor raw",   4'b0110, 16'hF0F0, 16'hFF00, 0, 1, 0, 0, 16'h0FF0, 0);
    op16("andn",      4'b0111, 16'hF0F0, 16'hFF00, 0, 0, 0, 0, 16'h00F0, 0);
    op16("rev",       4'b1000, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h2C48, 0);
    op16("reserved",  4'b1011, 16'hFFFF, 16'hFFFF, 1, 0, 0, 1, 16'h0000, 0);
    op16("pass invB", 4'b1100, 16'h1234, 16'h00FF, 0, 0, 1, 0, 16'hFF00, 0);
    op16("slbi",      4'b1111, 16'h12AB, 16'hCD34, 0, 0, 0, 0, 16'hAB34, 0);

    // Multiply (tag, op, A, B, sign, Out, Ofl)
    mul16("mul s -2*3",   4'b1001, 16'hFFFE, 16'h0003, 1, 16'hFFFA, 0);
    mul16("mulh s -2*3",  4'b1010, 16'hFFFE, 16'h0003, 1, 16'hFFFF, 0);
    mul16("mul s min*min",4'b1001, 16'h8000, 16'h8000, 1, 16'h0000, 1);
    mul16("mulh s min*min",4'b1010,16'h8000, 16'h8000, 1, 16'h4000, 0);
    mul16("mul s min*1",  4'b1001, 16'h8000, 16'h0001, 1, 16'h8000, 0);
    mul16("mul u max",    4'b1001, 16'hFFFF, 16'hFFFF, 0, 16'h0001, 1);
    mul16("mulh u max",   4'b1010, 16'hFFFF, 16'hFFFF, 0, 16'hFFFE, 0);

    // Back-to-back stream, then backpressure
    b16.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      set16(s_op[i], s_a[i], s_b[i], 1'b0, 1'b0, 1'b0, 1'b0);
      b16.in_valid = 1'b1;
      tick();
      chk($sformatf("stream%0d out", i), b16.Out, s_exp[i]);
      chk($sformatf("stream%0d valid", i), b16.out_valid, 1'b1);
      chk($sformatf("stream%0d in_ready", i), b16.in_ready, 1'b1);
    end
    set16(4'b1100, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    b16.out_ready = 1'b0;
    #1;
    chk("stall in_ready", b16.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d in_ready", i), b16.in_ready, 1'b0);
      chk($sformatf("stall%0d out", i), b16.Out, 16'hFFFE);
      chk($sformatf("stall%0d valid", i), b16.out_valid, 1'b1);
    end
    b16.out_ready = 1'b1;
    #1;
    chk("unstall in_ready", b16.in_ready, 1'b1);
    tick();
    b16.in_valid = 1'b0;
    chk("unstall out", b16.Out, 16'h5555);
    tick();
    chk("unstall drained", b16.out_valid, 1'b0);

    // Reset in the middle of a multiply
    set16(4'b1001, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    repeat (5) tick();
    chk("pre-rst busy", b16.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midmul rst busy", b16.busy, 1'b0);
    chk("midmul rst valid", b16.out_valid, 1'b0);
    chk("midmul rst out", b16.Out, 16'h0000);
    chk("midmul rst z", b16.Z, 1'b1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b16.out_valid !== 1'b0 || b16.busy !== 1'b0) seen++;
    end
    chk("post-rst quiet", seen, 0);
    op16("post-rst add", 4'b0100, 16'h0010, 16'h0020, 1, 0, 0, 0, 16'h0031, 0);

    // WIDTH=32 unsigned multiply overflow
    b32.Op = 4'b1001; b32.A = 32'h0001_0000; b32.B = 32'h0001_0000; b32.sign = 1'b0;
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    k = 0;
    while (b32.out_valid !== 1'b1 && k < 80) begin
      tick();
      k++;
    end
    chk("mul32 latency", k, 33);
    chk("mul32 out", b32.Out, 32'h0000_0000);
    chk("mul32 z", b32.Z, 1'b1);
    chk("mul32 ofl", b32.Ofl, 1'b1);

    // WIDTH=8 rotate and SLBI
    op8("w8 rotr1", 4'b0010, 8'h81, 8'h01, 8'hC0);
    op8("w8 slbi",  4'b1110, 8'h12, 8'h34, 8'h24);
    op8("w8 rotl7", 4'b0000, 8'h01, 8'h07, 8'h80);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-count width taken from B_new[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state SHALL change on rising edge only.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  adder carry-in.
REQ-010 Op  input  4  operation select (REQ-015).
REQ-011 invA  input  1  use ~A as A_new; invB  input  1  use ~B as B_new.
REQ-012 sign  input  1  1 = signed semantics for Ofl and MUL/MULH.
REQ-013 out_valid  output  1  result registers hold a valid result.
REQ-014 out_ready  input  1  consumer takes result; Out, Ofl, Z, resultSign  output  WIDTH/1/1/1  registered result, overflow, zero flag, Out[WIDTH-1]; busy  output  1  multiply in progress.

Function
REQ-015 Op decode, all on A_new/B_new unless noted:
- 0000 rotate left, 0001 shift left logical, 0010 rotate right, 0011 shift right logical; A_new by B_new[SHW-1:0].
- 0100 A_new+B_new+Cin; 0101 B_new-A_new; 0110 A^B (raw); 0111 A&~B (raw).
- 1000 bit-reverse A_new; 1001 MUL low WIDTH bits; 1010 MULH high WIDTH bits; 1011 reserved, Out=0.
- 1100/1101 pass B_new; 1110/1111 SLBI = (A << WIDTH/2) | B[WIDTH/2-1:0] (raw).
REQ-016 Transfer occurs when in_valid && in_ready; operands, Op, sign, Cin SHALL be captured on that edge.
REQ-017 in_ready SHALL be 1 iff state is IDLE and (out_valid==0 or out_ready==1).
REQ-018 FSM states: IDLE, MUL. IDLE --transfer of Op 1001/1010--> MUL; MUL --counter reaches WIDTH--> IDLE with result load; all other transfers stay IDLE.
REQ-019 Single-cycle ops: result registers load on the transfer edge; out_valid=1 the following cycle (latency 1).
REQ-020 MUL/MULH: iterative shift-add, one multiplier bit per cycle; out_valid SHALL rise exactly WIDTH+1 cycles after transfer edge; busy=1 throughout MUL state.
REQ-021 Signed multiply (sign=1): magnitudes captured at transfer; 2WIDTH-bit product negated at load when operand signs differ; most-negative operands SHALL give correct two's-complement result.
REQ-022 Ofl for 0100: sign=0 -> carry out; sign=1 -> carry-out XOR carry into MSB. Ofl for 0101 SHALL be 0.
REQ-023 Ofl for 1001: sign=0 -> product high half nonzero; sign=1 -> high half not equal to sign-extension of low-half MSB. All other ops Ofl=0.
REQ-024 Z SHALL be 1 iff registered Out==0; resultSign SHALL equal Out[WIDTH-1].
REQ-025 While out_valid && !out_ready, Out/Ofl/Z/resultSign SHALL hold stable and in_ready=0.
REQ-026 out_valid && out_ready && new transfer same edge: new single-cycle result SHALL load, out_valid stays 1 (back-to-back throughput 1/cycle).
REQ-027 out_valid && out_ready with no transfer: out_valid SHALL clear next cycle; Out retains last value.
REQ-028 Shift count 0 SHALL return A_new unchanged; count WIDTH-1 SHALL be honoured exactly.
REQ-029 Reserved Op 1011 SHALL complete in 1 cycle with Out=0, Z=1, Ofl=0.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, multiply counter 0, out_valid=0, busy=0, Out=0, Ofl=0, Z=1, resultSign=0.
REQ-031 Reset during MUL SHALL abandon the operation; no result SHALL appear after release.
REQ-032 First transfer SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 WIDTH=16, Op=0100, sign=1, A=16'h7FFF, B=16'h0001, Cin=0 -> next cycle Out=16'h8000, Ofl=1, resultSign=1, Z=0.
REQ-034 WIDTH=16, Op=1001, sign=1, A=16'hFFFE(-2), B=16'h0003 -> out_valid exactly 17 cycles later, Out=16'hFFFA, Ofl=0; repeat Op=1010 -> Out=16'hFFFF.
REQ-035 WIDTH=32, Op=1001, sign=0, A=B=32'h0001_0000 -> Out=0, Z=1, Ofl=1.
REQ-036 Stream 4 single-cycle ops with out_ready=1 -> 4 results on consecutive cycles; then out_ready=0 for 3 cycles -> in_ready=0, Out stable.
REQ-037 Assert rst_n=0 at cycle 5 of a WIDTH=16 MUL -> out_valid, busy 0 immediately; no out_valid for 20 cycles after release without new request.
REQ-038 WIDTH=8, Op=0010, A=8'h81, B=8'h01 -> Out=8'hC0; Op=1110, A=8'h12, B=8'h34 -> Out=8'h24.
